// File: rtl/grant_decoder.sv
// Receive side of the priority-encoder link: turns an accepted index into a
// registered one-hot grant, holds it until done or a hold limit, then idles one cycle.
module grant_decoder #(
  parameter int CODE_W   = 2,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2**CODE_W-1:0] grant,
  input  logic [2**CODE_W-1:0] done,
  output logic                 busy,
  output logic                 timeout
);

  localparam int N = 2**CODE_W;
  localparam logic [N-1:0]     GRANT_BASE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  // Only done[code_q] can end a grant; a release by done wins over the hold limit.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (in_valid) begin
          state_d   = GRANT;
          code_d    = in_code;
          grant_d   = GRANT_BASE << in_code;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      GRANT: begin
        if (done[code_q]) begin
          state_d   = GAP;
          grant_d   = '0;
          timeout_d = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = GAP;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        state_d   = IDLE;
        grant_d   = '0;
        timeout_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      code_q    <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign grant    = grant_q;
  assign timeout  = timeout_q;

endmodule
